// File: rtl/axis_arb_mux_pkg.sv
// Shared types and helpers for the round-robin AXI-Stream arbiter/mux.
// Holds the FSM state encoding and the grant-index width function.
package axis_arb_mux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axis_arb_mux_rr_arbiter.sv
// Combinational round-robin picker: first requester strictly after i_ptr,
// wrapping past the top channel back to 0 (i_ptr itself is checked last).
module rr_arbiter
  import axis_arb_mux_pkg::*;
#(
  parameter  int N_CH = 8,
  localparam int CH_W = ch_w(N_CH)
) (
  input  logic [N_CH-1:0] i_req,
  input  logic [CH_W-1:0] i_ptr,
  output logic [CH_W-1:0] o_winner,
  output logic            o_any_req
);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_winner = '0;
    w_found  = 1'b0;
    w_idx    = 0;
    for (int k = 1; k <= N_CH; k++) begin
      w_idx = (int'(i_ptr) + k) % N_CH;
      if (!w_found && i_req[w_idx[CH_W-1:0]]) begin
        o_winner = w_idx[CH_W-1:0];
        w_found  = 1'b1;
      end
    end
  end

  assign o_any_req = |i_req;

endmodule

// File: rtl/axis_arb_mux.sv
// N_CH-to-1 AXI-Stream mux with round-robin grant and a one-beat output register.
// Define AXIS_ARB_MUX_LOCK_EN to hold the grant for a whole packet (until s_last).
module axis_arb_mux
  import axis_arb_mux_pkg::*;
#(
  parameter  int N_CH  = 8,
  parameter  int WIDTH = 16,
  localparam int CH_W  = ch_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH*WIDTH-1:0] s_data,
  input  logic [N_CH-1:0]       s_valid,
  input  logic [N_CH-1:0]       s_last,
  output logic [N_CH-1:0]       s_ready,
  output logic [WIDTH-1:0]      m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [CH_W-1:0]       grant_id
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_grant;
  logic [CH_W-1:0]   r_rr_ptr;
  logic [WIDTH-1:0]  r_m_data;
  logic              r_m_valid;
  logic              r_m_last;

  logic [CH_W-1:0]   w_winner;
  logic              w_any_req;
  logic              w_gnt_valid;
  logic              w_gnt_last;
  logic [WIDTH-1:0]  w_gnt_data;
  logic              w_slot_free;
  logic              w_accept;
  logic              w_arb;
  logic [N_CH-1:0]   w_s_ready;

  rr_arbiter #(.N_CH(N_CH)) u_rr_arbiter (
    .i_req     (s_valid),
    .i_ptr     (r_rr_ptr),
    .o_winner  (w_winner),
    .o_any_req (w_any_req)
  );

  assign w_gnt_valid = s_valid[r_grant];
  assign w_gnt_last  = s_last[r_grant];
  assign w_gnt_data  = s_data[int'(r_grant)*WIDTH +: WIDTH];
  // The output register can take a new beat if empty or draining this cycle.
  assign w_slot_free = !r_m_valid || m_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = '0;
    w_accept    = 1'b0;
    w_arb       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_arb       = 1'b1;
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        w_s_ready[r_grant] = w_slot_free;
        w_accept           = w_slot_free && w_gnt_valid;
`ifdef AXIS_ARB_MUX_LOCK_EN
        if (w_accept && w_gnt_last) w_state_nxt = IDLE;
`else
        if (w_accept) w_state_nxt = IDLE;
`endif
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant   <= '0;
      r_rr_ptr  <= CH_W'(N_CH - 1);
      r_m_data  <= '0;
      r_m_last  <= 1'b0;
      r_m_valid <= 1'b0;
    end else begin
      if (w_arb) begin
        r_grant  <= w_winner;
        r_rr_ptr <= w_winner;
      end
      if (w_accept) begin
        r_m_data  <= w_gnt_data;
        r_m_last  <= w_gnt_last;
        r_m_valid <= 1'b1;
      end else if (m_ready) begin
        r_m_valid <= 1'b0;
      end
    end
  end

  assign s_ready  = w_s_ready;
  assign m_data   = r_m_data;
  assign m_valid  = r_m_valid;
  assign m_last   = r_m_last;
  assign grant_id = r_grant;

endmodule

// File: tb/tb_axis_arb_mux.sv
// Scoreboard bench for axis_arb_mux: per-channel packet drivers, a decoupled output
// monitor, directed ordering scenarios and a randomized traffic run.
module tb_axis_arb_mux;

  localparam int N_CH  = 8;
  localparam int WIDTH = 16;
  localparam int CH_W  = 3;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [N_CH*WIDTH-1:0] s_data = '0;
  logic [N_CH-1:0]       s_valid = '0;
  logic [N_CH-1:0]       s_last = '0;
  logic [N_CH-1:0]       s_ready;
  logic [WIDTH-1:0]      m_data;
  logic                  m_valid;
  logic                  m_last;
  logic                  m_ready = 1'b0;
  logic [CH_W-1:0]       grant_id;

  axis_arb_mux #(.N_CH(N_CH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_ready  (m_ready),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
    int               gap;
  } beat_t;

  beat_t src_q [N_CH][$];
  beat_t ch_q  [N_CH][$];
  beat_t exp_q [$];
  bit    ordered = 1'b1;
  int    checks = 0;
  int    errors = 0;
  int    n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #3;
  endtask

  // Drivers: each channel presents the head of its queue after an optional idle gap.
  initial begin : driver
    bit armed [N_CH];
    int gap_left [N_CH];
    logic [N_CH-1:0] fire;
    bit flush;
    for (int i = 0; i < N_CH; i++) begin
      armed[i] = 1'b0;
      gap_left[i] = 0;
    end
    forever begin
      @(negedge clk);
      #4;
      fire  = s_valid & s_ready;
      flush = rst;
      @(posedge clk);
      #1;
      for (int i = 0; i < N_CH; i++) begin
        if (flush) begin
          src_q[i].delete();
          armed[i] = 1'b0;
        end else if (fire[i]) begin
          void'(src_q[i].pop_front());
          armed[i] = 1'b0;
        end
        if (src_q[i].size() == 0) begin
          s_valid[i] = 1'b0;
        end else begin
          if (!armed[i]) begin
            gap_left[i] = src_q[i][0].gap;
            armed[i] = 1'b1;
          end
          if (gap_left[i] > 0) begin
            s_valid[i] = 1'b0;
            gap_left[i]--;
          end else begin
            s_valid[i] = 1'b1;
            s_data[i*WIDTH +: WIDTH] = src_q[i][0].data;
            s_last[i] = src_q[i][0].last;
          end
        end
      end
    end
  end

  // Monitor: checks every transferred output beat and output stability under back-pressure.
  initial begin : monitor
    logic             prev_stall;
    logic [WIDTH-1:0] prev_data;
    logic             prev_last;
    int               lock_ch;
    int               ch;
    beat_t            e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    lock_ch    = -1;
    forever begin
      @(negedge clk);
      #4;
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < N_CH; i++) ch_q[i].delete();
        prev_stall = 1'b0;
        lock_ch = -1;
      end else begin
        if (prev_stall) begin
          chk("hold m_valid", 32'(m_valid), 1);
          chk("hold m_data", 32'(m_data), 32'(prev_data));
          chk("hold m_last", 32'(m_last), 32'(prev_last));
        end
        if (m_valid && m_ready) begin
          n_out++;
          if (ordered) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected beat: got %0h, expected no beat", m_data);
            end else begin
              e = exp_q.pop_front();
              chk("ordered beat data", 32'(m_data), 32'(e.data));
              chk("ordered beat last", 32'(m_last), 32'(e.last));
            end
          end else begin
            ch = int'(m_data[WIDTH-1 -: 4]);
            if (ch >= N_CH) begin
              checks++;
              errors++;
              $display("FAIL channel tag: got %0d, expected below %0d", ch, N_CH);
            end else if (ch_q[ch].size() == 0) begin
              checks++;
              errors++;
              $display("FAIL extra beat ch%0d: got %0h, expected no beat", ch, m_data);
            end else begin
              e = ch_q[ch].pop_front();
              chk("random beat data", 32'(m_data), 32'(e.data));
              chk("random beat last", 32'(m_last), 32'(e.last));
            end
`ifdef AXIS_ARB_MUX_LOCK_EN
            if (lock_ch >= 0) chk("packet atomic", 32'(ch), 32'(lock_ch));
            lock_ch = m_last ? -1 : ch;
`endif
          end
        end
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
      end
    end
  end

  task automatic add_beat(input int ch, input logic [WIDTH-1:0] d, input logic l, input int gap);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = gap;
    src_q[ch].push_back(b);
  endtask

  task automatic expect_beat(input logic [WIDTH-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    b.gap  = 0;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    bit busy;
    n = 0;
    busy = 1'b1;
    while (busy && n < budget) begin
      tick();
      n++;
      busy = (exp_q.size() != 0);
      for (int i = 0; i < N_CH; i++) if (ch_q[i].size() != 0) busy = 1'b1;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL %s drain: beats still outstanding after %0d cycles, expected none", name, n);
    end
    tick();
    tick();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : test
    int n;
    int n0;
    int total;
    int ch;
    int len;
    int seq [N_CH];
    logic [WIDTH-1:0] d;

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    tick();
    chk("reset m_valid", 32'(m_valid), 0);
    chk("reset m_data", 32'(m_data), 0);
    chk("reset m_last", 32'(m_last), 0);
    chk("reset grant_id", 32'(grant_id), 0);
    chk("reset s_ready", 32'(s_ready), 0);
    rst = 1'b0;

    // Two 3-beat packets on channels 2 and 5
    do_reset();
    m_ready = 1'b1;
    for (int b = 1; b <= 3; b++) begin
      add_beat(2, 16'(32'h2000 + b), (b == 3), 0);
      add_beat(5, 16'(32'h5000 + b), (b == 3), 0);
    end
`ifdef AXIS_ARB_MUX_LOCK_EN
    for (int b = 1; b <= 3; b++) expect_beat(16'(32'h2000 + b), (b == 3));
    for (int b = 1; b <= 3; b++) expect_beat(16'(32'h5000 + b), (b == 3));
`else
    for (int b = 1; b <= 3; b++) begin
      expect_beat(16'(32'h2000 + b), (b == 3));
      expect_beat(16'(32'h5000 + b), (b == 3));
    end
`endif
    wait_drain("ch2/ch5 packets", 60);

    // All channels valid: grants 0..7 then 0 again
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < N_CH; i++) add_beat(i, 16'(32'hB000 + i), 1'b1, 0);
    add_beat(0, 16'hB0F0, 1'b1, 0);
    for (int i = 0; i < N_CH; i++) expect_beat(16'(32'hB000 + i), 1'b1);
    expect_beat(16'hB0F0, 1'b1);
    wait_drain("fairness", 80);

    // Back-pressure: output held for 4 cycles with m_ready low
    do_reset();
    m_ready = 1'b0;
    add_beat(6, 16'hA5A5, 1'b0, 0);
    add_beat(6, 16'h5A5A, 1'b1, 0);
    expect_beat(16'hA5A5, 1'b0);
    expect_beat(16'h5A5A, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("stall m_valid seen", 32'(m_valid), 1);
    for (int k = 0; k < 4; k++) begin
      chk("stall m_data", 32'(m_data), 32'hA5A5);
      chk("stall s_ready", 32'(s_ready[6]), 0);
      chk("stall grant_id", 32'(grant_id), 6);
      if (k < 3) tick();
    end
    m_ready = 1'b1;
    #1;
    chk("release s_ready", 32'(s_ready[6]), 1);
    wait_drain("stall", 30);

    // Granted channel pauses mid-packet while channel 3 waits
    do_reset();
    m_ready = 1'b1;
    add_beat(1, 16'h1A01, 1'b0, 0);
    add_beat(1, 16'h1A02, 1'b0, 0);
    add_beat(1, 16'h1A03, 1'b0, 2);
    add_beat(1, 16'h1A04, 1'b1, 0);
    add_beat(3, 16'h3A01, 1'b1, 0);
`ifdef AXIS_ARB_MUX_LOCK_EN
    expect_beat(16'h1A01, 1'b0);
    expect_beat(16'h1A02, 1'b0);
    expect_beat(16'h1A03, 1'b0);
    expect_beat(16'h1A04, 1'b1);
    expect_beat(16'h3A01, 1'b1);
`else
    expect_beat(16'h1A01, 1'b0);
    expect_beat(16'h3A01, 1'b1);
    expect_beat(16'h1A02, 1'b0);
    expect_beat(16'h1A03, 1'b0);
    expect_beat(16'h1A04, 1'b1);
`endif
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
      if (!s_valid[1] && src_q[1].size() != 0 && src_q[1].size() < 4) begin
        chk("gap grant_id", 32'(grant_id), 1);
        chk("gap s_ready ch3", 32'(s_ready[3]), 0);
      end
    end
    wait_drain("mid-packet gap", 20);

    // Channels 1 and 4, two beats each
    do_reset();
    m_ready = 1'b1;
    add_beat(1, 16'h1B01, 1'b0, 0);
    add_beat(1, 16'h1B02, 1'b1, 0);
    add_beat(4, 16'h4B01, 1'b0, 0);
    add_beat(4, 16'h4B02, 1'b1, 0);
`ifdef AXIS_ARB_MUX_LOCK_EN
    expect_beat(16'h1B01, 1'b0);
    expect_beat(16'h1B02, 1'b1);
    expect_beat(16'h4B01, 1'b0);
    expect_beat(16'h4B02, 1'b1);
`else
    expect_beat(16'h1B01, 1'b0);
    expect_beat(16'h4B01, 1'b0);
    expect_beat(16'h1B02, 1'b1);
    expect_beat(16'h4B02, 1'b1);
`endif
    wait_drain("ch1/ch4 interleave", 40);

    // Reset while beat 2 of a 4-beat packet is held
    do_reset();
    m_ready = 1'b1;
    for (int b = 1; b <= 4; b++) begin
      add_beat(2, 16'(32'h2C00 + b), (b == 4), 0);
      expect_beat(16'(32'h2C00 + b), (b == 4));
    end
    n = 0;
    while (!(m_valid && m_data == 16'h2C02) && n < 30) begin
      tick();
      n++;
    end
    chk("beat2 presented", 32'(m_valid && m_data == 16'h2C02), 1);
    m_ready = 1'b0;
    rst = 1'b1;
    tick();
    chk("post-reset m_valid", 32'(m_valid), 0);
    chk("post-reset s_ready", 32'(s_ready), 0);
    chk("post-reset grant_id", 32'(grant_id), 0);
    rst = 1'b0;
    m_ready = 1'b1;
    add_beat(5, 16'h5C01, 1'b1, 0);
    add_beat(0, 16'h0C01, 1'b1, 0);
    expect_beat(16'h0C01, 1'b1);
    expect_beat(16'h5C01, 1'b1);
    n = 0;
    while (!m_valid && n < 20) begin
      tick();
      n++;
    end
    chk("first grant after reset", 32'(grant_id), 0);
    wait_drain("after reset", 30);

    // Randomized traffic with gaps and random back-pressure
    do_reset();
    ordered = 1'b0;
    for (int i = 0; i < N_CH; i++) seq[i] = 0;
    n0 = n_out;
    total = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      m_ready = ($urandom_range(0, 3) != 0);
      if (cyc < 300 && $urandom_range(0, 3) == 0) begin
        ch  = int'($urandom_range(0, N_CH - 1));
        len = int'($urandom_range(1, 4));
        for (int b = 0; b < len; b++) begin
          beat_t bt;
          d = {4'(ch), 12'(seq[ch])};
          seq[ch]++;
          bt.data = d;
          bt.last = (b == len - 1);
          bt.gap  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
          src_q[ch].push_back(bt);
          ch_q[ch].push_back(bt);
          total++;
        end
      end
    end
    m_ready = 1'b1;
    wait_drain("random", 600);
    chk("random beat count", 32'(n_out - n0), 32'(total));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
